// File: rtl/playback_sequencer.sv
// Step-clock and playback controller: turns a latched BPM into step ticks with a phase
// accumulator and counts pattern passes, handing play_en back to the keyboard interface.
module playback_sequencer #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned STEPS  = 16,
   parameter int unsigned STEP_W = 4
) (
   input  logic              CLOCK_50,
   input  logic              nReset,
   input  logic [9:0]        BPM,
   input  logic [6:0]        Loops,
   input  logic              Start,
   output logic              play_en,
   output logic              playing,
   output logic              step_tick,
   output logic [STEP_W-1:0] step_idx,
   output logic [6:0]        loop_idx,
   output logic              done
);

   // One step per beat: a boundary occurs whenever the accumulator crosses CLK_HZ*60.
   localparam logic [31:0]       DEN       = 32'(64'(CLK_HZ) * 64'd60);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e      r_state;
   logic [31:0] r_acc;
   logic [9:0]  r_bpm;
   logic [6:0]  r_loops;

   logic [31:0] w_sum;
   logic        w_boundary;
   logic        w_last_loop;

   // acc < DEN <= 3e9 and bpm <= 1023, so the sum never wraps 32 bits.
   assign w_sum       = r_acc + {22'd0, r_bpm};
   assign w_boundary  = (w_sum >= DEN);
   assign w_last_loop = ((loop_idx + 7'd1) == r_loops);

   always_ff @(posedge CLOCK_50 or negedge nReset) begin
      if (!nReset) begin
         r_state   <= StIdle;
         r_acc     <= '0;
         r_bpm     <= '0;
         r_loops   <= '0;
         play_en   <= 1'b1;
         playing   <= 1'b0;
         step_tick <= 1'b0;
         step_idx  <= '0;
         loop_idx  <= '0;
         done      <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         done      <= 1'b0;
         case (r_state)
            StIdle: begin
               play_en  <= 1'b1;
               playing  <= 1'b0;
               r_acc    <= '0;
               step_idx <= '0;
               loop_idx <= '0;
               if (Start && (BPM != '0)) begin
                  r_bpm     <= BPM;
                  r_loops   <= (Loops == '0) ? 7'd1 : Loops;
                  r_state   <= StRun;
                  playing   <= 1'b1;
                  step_tick <= 1'b1;
               end
            end
            StRun: begin
               // Abort wins over a boundary landing in the same cycle.
               if (!Start) begin
                  r_state  <= StIdle;
                  playing  <= 1'b0;
                  step_idx <= '0;
                  loop_idx <= '0;
               end else begin
                  r_acc <= w_boundary ? (w_sum - DEN) : w_sum;
                  if (w_boundary) begin
                     if (step_idx != LAST_STEP) begin
                        step_idx  <= step_idx + STEP_W'(1);
                        step_tick <= 1'b1;
                     end else if (w_last_loop) begin
                        r_state  <= StDone;
                        play_en  <= 1'b0;
                        playing  <= 1'b0;
                        done     <= 1'b1;
                        loop_idx <= r_loops;
                     end else begin
                        step_idx  <= '0;
                        loop_idx  <= loop_idx + 7'd1;
                        step_tick <= 1'b1;
                     end
                  end
               end
            end
            StDone: begin
               if (!Start) begin
                  r_state  <= StIdle;
                  play_en  <= 1'b1;
                  step_idx <= '0;
                  loop_idx <= '0;
               end
            end
            default: begin
               r_state  <= StIdle;
               r_acc    <= '0;
               play_en  <= 1'b1;
               playing  <= 1'b0;
               step_idx <= '0;
               loop_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_playback_sequencer.sv
// Randomized bench for playback_sequencer: a closed-form model counts step boundaries as
// floor(cycles*bpm/DEN) and predicts every output each cycle.
module tb_playback_sequencer;

   localparam int unsigned CLK_HZ = 100;
   localparam int unsigned STEPS  = 4;
   localparam int unsigned STEP_W = 2;
   localparam longint      DEN    = 6000;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b1;
   logic              start  = 1'b0;
   logic [9:0]        bpm    = '0;
   logic [6:0]        loops  = '0;
   logic              play_en;
   logic              playing;
   logic              step_tick;
   logic [STEP_W-1:0] step_idx;
   logic [6:0]        loop_idx;
   logic              done;

   playback_sequencer #(
      .CLK_HZ (CLK_HZ),
      .STEPS  (STEPS),
      .STEP_W (STEP_W)
   ) dut (
      .CLOCK_50  (clk),
      .nReset    (rst_n),
      .BPM       (bpm),
      .Loops     (loops),
      .Start     (start),
      .play_en   (play_en),
      .playing   (playing),
      .step_tick (step_tick),
      .step_idx  (step_idx),
      .loop_idx  (loop_idx),
      .done      (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: 0 idle, 1 run, 2 done; m_c counts cycles since the start edge.
   int                m_mode  = 0;
   longint            m_c     = 0;
   longint            m_bpm   = 0;
   longint            m_loops = 0;
   logic              e_play_en = 1'b1;
   logic              e_playing = 1'b0;
   logic              e_tick    = 1'b0;
   logic [STEP_W-1:0] e_step    = '0;
   logic [6:0]        e_loop    = '0;
   logic              e_done    = 1'b0;

   int n_ticks = 0;
   int n_dones = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] act_vec();
      return {play_en, playing, step_tick, step_idx, loop_idx, done};
   endfunction

   function automatic logic [12:0] exp_vec();
      return {e_play_en, e_playing, e_tick, e_step, e_loop, e_done};
   endfunction

   task automatic set_idle();
      e_play_en = 1'b1;
      e_playing = 1'b0;
      e_step    = '0;
      e_loop    = '0;
   endtask

   task automatic model_step();
      longint b, pb, total;
      e_tick = 1'b0;
      e_done = 1'b0;
      case (m_mode)
         0: begin
            if (start && (bpm != 0)) begin
               m_mode    = 1;
               m_c       = 0;
               m_bpm     = longint'(bpm);
               m_loops   = (loops == 0) ? 1 : longint'(loops);
               e_tick    = 1'b1;
               e_playing = 1'b1;
               e_play_en = 1'b1;
               e_step    = '0;
               e_loop    = '0;
            end else begin
               set_idle();
            end
         end
         1: begin
            if (!start) begin
               m_mode = 0;
               set_idle();
            end else begin
               m_c++;
               b     = (m_c * m_bpm) / DEN;
               pb    = ((m_c - 1) * m_bpm) / DEN;
               total = longint'(STEPS) * m_loops;
               if (b >= total) begin
                  m_mode    = 2;
                  e_done    = 1'b1;
                  e_play_en = 1'b0;
                  e_playing = 1'b0;
                  e_step    = STEP_W'(STEPS - 1);
                  e_loop    = 7'(m_loops);
               end else begin
                  e_tick = (b != pb);
                  e_step = STEP_W'(b % longint'(STEPS));
                  e_loop = 7'(b / longint'(STEPS));
               end
            end
         end
         default: begin
            if (!start) begin
               m_mode = 0;
               set_idle();
            end
         end
      endcase
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("outs", 64'(act_vec()), 64'(exp_vec()));
      if (step_tick) n_ticks++;
      if (done) n_dones++;
   endtask

   // Starts a run and returns cycles from the first tick to the done cycle.
   task automatic run_to_done(input int bound, output int len);
      start = 1'b1;
      cycle();
      len = 0;
      while (m_mode == 1 && len < bound) begin
         cycle();
         len++;
      end
      if (m_mode != 2) check("run_timeout", 64'(m_mode), 64'd2);
   endtask

   int len;
   int k;

   initial begin
      #2 rst_n = 1'b0;
      #2 check("reset_outs", 64'(act_vec()), 64'(13'b1_0_0_00_0000000_0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      set_idle();
      repeat (2) cycle();

      // Basic run with handshake hold after done.
      bpm = 10'd600; loops = 7'd2; n_ticks = 0; n_dones = 0;
      run_to_done(500, len);
      check("basic_len", 64'(len), 64'd80);
      repeat (5) cycle();
      check("basic_ticks", 64'(n_ticks), 64'd8);
      check("basic_done_once", 64'(n_dones), 64'd1);
      check("hold_play_en", 64'(play_en), 64'd0);
      start = 1'b0;
      cycle();
      check("release_play_en", 64'(play_en), 64'd1);

      // Fractional rate.
      bpm = 10'd700; loops = 7'd1;
      run_to_done(500, len);
      check("frac_len", 64'(len), 64'd35);
      start = 1'b0;
      cycle();

      // Latched BPM: mid-run change is ignored.
      bpm = 10'd600; loops = 7'd1;
      start = 1'b1;
      cycle();
      repeat (15) cycle();
      bpm = 10'd300;
      len = 16;
      while (m_mode == 1 && len < 500) begin
         cycle();
         len++;
      end
      check("latch_len", 64'(len - 1), 64'd40);
      start = 1'b0;
      cycle();

      // Abort mid step 2, then no ticks while idle.
      bpm = 10'd600; loops = 7'd3; start = 1'b1;
      repeat (26) cycle();
      check("abort_pre_step", 64'(step_idx), 64'd2);
      start = 1'b0;
      cycle();
      check("abort_playing", 64'(playing), 64'd0);
      n_ticks = 0;
      repeat (20) cycle();
      check("abort_no_ticks", 64'(n_ticks), 64'd0);

      // Loops=0 acts as one pass.
      bpm = 10'd1000; loops = 7'd0;
      run_to_done(500, len);
      check("loops0_loop_idx", 64'(loop_idx), 64'd1);
      start = 1'b0;
      cycle();

      // BPM=0 never leaves idle.
      bpm = 10'd0; start = 1'b1;
      repeat (10) cycle();
      check("bpm0_playing", 64'(playing), 64'd0);
      start = 1'b0;
      cycle();

      // Randomized runs with ignored mid-run input changes and occasional aborts.
      for (int r = 0; r < 20; r++) begin
         bpm   = 10'($urandom_range(200, 1023));
         loops = 7'($urandom_range(0, 3));
         start = 1'b1;
         cycle();
         k = 0;
         while (m_mode == 1 && k < 2000) begin
            if ($urandom_range(0, 99) < 5) bpm = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 99) < 5) loops = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 199) == 0) start = 1'b0;
            cycle();
            k++;
         end
         if (m_mode == 1) check("rand_timeout", 64'(m_mode), 64'd2);
         repeat ($urandom_range(0, 3)) cycle();
         start = 1'b0;
         repeat (2) cycle();
      end

      // Asynchronous reset in the middle of a run.
      bpm = 10'd600; loops = 7'd2; start = 1'b1;
      repeat (24) cycle();
      @(posedge clk);
      model_step();
      #3 rst_n = 1'b0;
      #1 check("async_reset", 64'(act_vec()), 64'(13'b1_0_0_00_0000000_0));
      m_mode = 0;
      set_idle();
      e_tick = 1'b0;
      e_done = 1'b0;
      start  = 1'b0;
      @(posedge clk);
      #1 check("reset_held", 64'(act_vec()), 64'(13'b1_0_0_00_0000000_0));
      rst_n = 1'b1;
      repeat (2) cycle();
      bpm = 10'd600; loops = 7'd1;
      run_to_done(500, len);
      check("post_reset_len", 64'(len), 64'd40);
      start = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
